pico_sequencer: RTL and testbench

Multi-cycle control FSM for the picoMIPS datapath. It replaces purely combinational single-cycle decoding with a fetch/decode/execute/writeback sequence. It drives the PC, immediate mux, register-file write, ALU function and multiplier start. It stalls on the multiplier and on a user switch handshake. It sits between program memory (opcode source) and the PC, register file, ALU and multiplier.

---
 rtl/pico_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_pico_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pico_sequencer.sv
// pico_sequencer: multi-cycle fetch/decode/execute/writeback controller for
// the picoMIPS datapath. It steers the PC, the immediate mux, the register-file
// write, the ALU function and the multiplier start. It stalls on the multiplier
// and on a two-phase user switch handshake.
module pico_sequencer #(
  parameter int MUL_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] instr_opcode,
  input  logic       z,
  input  logic       mul_done,
  input  logic       sw_go,
  output logic       ir_load,
  output logic       PCincr,
  output logic       PCrelbranch,
  output logic       PCabsbranch,
  output logic       imm,
  output logic       w1,
  output logic [2:0] ALUfunc,
  output logic       mul_start,
  output logic       busy,
  output logic       fault
);

  // Opcode map
  localparam logic [5:0] OP_NOP    = 6'b000000;
  localparam logic [5:0] OP_ADD    = 6'b000001;
  localparam logic [5:0] OP_ADDI   = 6'b000010;
  localparam logic [5:0] OP_LDI    = 6'b000011;
  localparam logic [5:0] OP_MUL    = 6'b000100;
  localparam logic [5:0] OP_BEQ    = 6'b000101;
  localparam logic [5:0] OP_J      = 6'b000110;
  localparam logic [5:0] OP_WAITSW = 6'b000111;

  // ALU function codes
  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;

  // The MULWAIT cycle on which the counter holds this value is the last one
  // allowed; the counter counts MULWAIT cycles already spent.
  localparam logic [7:0] CNT_LAST = 8'(MUL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MULWAIT = 3'd3,
    S_SWWAIT  = 3'd4,
    S_WB      = 3'd5
  } state_t;

  state_t     state_reg,   state_next;
  logic [5:0] opcode_reg,  opcode_next;
  logic       fault_reg,   fault_next;
  logic [7:0] cnt_reg,     cnt_next;
  logic       pressed_reg, pressed_next;

  // Raw (pre-reset-gating) output values
  logic       ir_load_raw;
  logic       pc_incr_raw;
  logic       pc_rel_raw;
  logic       pc_abs_raw;
  logic       imm_raw;
  logic       w1_raw;
  logic [2:0] alu_raw;
  logic       mul_start_raw;
  logic       busy_raw;

  logic       opcode_legal;

  // Legal opcodes occupy the low eight codes
  always_comb begin
    opcode_legal = (opcode_reg[5:3] == 3'b000);
  end

  // State and datapath-control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      opcode_reg  <= OP_NOP;
      fault_reg   <= 1'b0;
      cnt_reg     <= 8'd0;
      pressed_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      opcode_reg  <= opcode_next;
      fault_reg   <= fault_next;
      cnt_reg     <= cnt_next;
      pressed_reg <= pressed_next;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next    = state_reg;
    opcode_next   = opcode_reg;
    fault_next    = fault_reg;
    cnt_next      = cnt_reg;
    pressed_next  = pressed_reg;
    ir_load_raw   = 1'b0;
    pc_incr_raw   = 1'b0;
    pc_rel_raw    = 1'b0;
    pc_abs_raw    = 1'b0;
    imm_raw       = 1'b0;
    w1_raw        = 1'b0;
    alu_raw       = ALU_PASS_B;
    mul_start_raw = 1'b0;
    busy_raw      = 1'b0;

    case (state_reg)
      S_FETCH: begin
        ir_load_raw = 1'b1;
        opcode_next = instr_opcode;
        state_next  = S_DECODE;
      end

      S_DECODE: begin
        // Illegal codes are flagged and then run as NOP by overwriting the
        // latched opcode, so EXEC and WB only ever see legal codes.
        if (!opcode_legal) begin
          fault_next  = 1'b1;
          opcode_next = OP_NOP;
        end
        state_next = S_EXEC;
      end

      S_EXEC: begin
        case (opcode_reg)
          OP_ADD: begin
            alu_raw    = ALU_ADD;
            state_next = S_WB;
          end
          OP_ADDI: begin
            alu_raw    = ALU_ADD;
            imm_raw    = 1'b1;
            state_next = S_WB;
          end
          OP_LDI: begin
            alu_raw    = ALU_PASS_B;
            imm_raw    = 1'b1;
            state_next = S_WB;
          end
          OP_BEQ: begin
            alu_raw     = ALU_SUB;
            pc_rel_raw  = z;
            pc_incr_raw = !z;
            state_next  = S_FETCH;
          end
          OP_J: begin
            pc_abs_raw = 1'b1;
            state_next = S_FETCH;
          end
          OP_MUL: begin
            mul_start_raw = 1'b1;
            cnt_next      = 8'd0;
            state_next    = S_MULWAIT;
          end
          OP_WAITSW: begin
            pressed_next = 1'b0;
            state_next   = S_SWWAIT;
          end
          default: begin
            pc_incr_raw = 1'b1;
            state_next  = S_FETCH;
          end
        endcase
      end

      S_MULWAIT: begin
        busy_raw = 1'b1;
        cnt_next = cnt_reg + 8'd1;
        // A result arriving on the final allowed cycle still wins.
        if (mul_done) begin
          state_next = S_WB;
        end else if (cnt_reg >= CNT_LAST) begin
          fault_next  = 1'b1;
          pc_incr_raw = 1'b1;
          state_next  = S_FETCH;
        end
      end

      S_SWWAIT: begin
        busy_raw = 1'b1;
        if (!pressed_reg) begin
          if (sw_go) begin
            pressed_next = 1'b1;
          end
        end else if (!sw_go) begin
          pc_incr_raw  = 1'b1;
          pressed_next = 1'b0;
          state_next   = S_FETCH;
        end
      end

      S_WB: begin
        w1_raw      = 1'b1;
        pc_incr_raw = 1'b1;
        // Hold the operand selection used in EXEC so the written value is stable.
        case (opcode_reg)
          OP_ADD:  alu_raw = ALU_ADD;
          OP_ADDI: begin
            alu_raw = ALU_ADD;
            imm_raw = 1'b1;
          end
          OP_LDI:  imm_raw = 1'b1;
          default: alu_raw = ALU_PASS_B;
        endcase
        state_next = S_FETCH;
      end

      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Reset forces every output low combinationally, so an aborted instruction
  // cannot strobe the PC or write the register file on the reset cycle.
  always_comb begin
    ir_load     = ir_load_raw   & ~reset;
    PCincr      = pc_incr_raw   & ~reset;
    PCrelbranch = pc_rel_raw    & ~reset;
    PCabsbranch = pc_abs_raw    & ~reset;
    imm         = imm_raw       & ~reset;
    w1          = w1_raw        & ~reset;
    ALUfunc     = alu_raw       & {3{~reset}};
    mul_start   = mul_start_raw & ~reset;
    busy        = busy_raw      & ~reset;
    fault       = fault_reg     & ~reset;
  end

endmodule

// File: tb/tb_pico_sequencer.sv
// tb_pico_sequencer: expands each instruction into its expected per-cycle
// input/output script from the instruction-level timing rules, then replays the
// script into the DUT and compares every cycle.
module tb_pico_sequencer;

  localparam int MUL_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] instr_opcode = 6'b000001;
  logic       z = 1'b0;
  logic       mul_done = 1'b0;
  logic       sw_go = 1'b0;
  logic       ir_load, PCincr, PCrelbranch, PCabsbranch, imm, w1;
  logic [2:0] ALUfunc;
  logic       mul_start, busy, fault;

  pico_sequencer #(.MUL_TIMEOUT(MUL_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .instr_opcode(instr_opcode), .z(z),
    .mul_done(mul_done), .sw_go(sw_go), .ir_load(ir_load), .PCincr(PCincr),
    .PCrelbranch(PCrelbranch), .PCabsbranch(PCabsbranch), .imm(imm), .w1(w1),
    .ALUfunc(ALUfunc), .mul_start(mul_start), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {ir_load, PCincr, PCrelbranch, PCabsbranch, imm,
  // w1, ALUfunc[2:0], mul_start, busy, fault}
  typedef struct packed {
    logic        rst;
    logic [5:0]  op;
    logic        zz;
    logic        md;
    logic        sw;
    logic [11:0] exp;
  } cyc_t;

  cyc_t stim_q[$];
  cyc_t tmp_q[$];
  logic fault_m = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic chk_en = 1'b0;
  logic [11:0] exp_cur = '0;
  int   cyc_idx = 0;

  function automatic logic [11:0] ev(input logic ir, input logic inc,
      input logic rel, input logic ab, input logic im, input logic wr,
      input logic [2:0] alu, input logic ms, input logic bz, input logic fl);
    return {ir, inc, rel, ab, im, wr, alu, ms, bz, fl};
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [5:0] op, input logic zz, input logic md,
                      input logic sw, input logic [11:0] e);
    cyc_t c;
    c.rst = 1'b0; c.op = op; c.zz = zz; c.md = md; c.sw = sw; c.exp = e;
    tmp_q.push_back(c);
  endtask

  // Instruction-level model: lat = cycle of MULWAIT on which mul_done arrives
  // (beyond MUL_TIMEOUT means never); pre/hi = sw_go low/high cycle counts.
  task automatic expand(input logic [5:0] op, input logic zb, input int lat,
                        input int pre, input int hi);
    logic [5:0] eff;
    logic [5:0] junk;
    junk = 6'($urandom);
    tmp_q.delete();
    push(op, rb(), rb(), rb(), ev(1,0,0,0,0,0,3'b000,0,0,fault_m));
    push(junk, rb(), rb(), rb(), ev(0,0,0,0,0,0,3'b000,0,0,fault_m));
    if (op > 6'd7) fault_m = 1'b1;
    eff = (op > 6'd7) ? 6'd0 : op;
    case (eff)
      6'd1: begin
        push(junk, rb(), rb(), rb(), ev(0,0,0,0,0,0,3'b001,0,0,fault_m));
        push(junk, rb(), rb(), rb(), ev(0,1,0,0,0,1,3'b001,0,0,fault_m));
      end
      6'd2: begin
        push(junk, rb(), rb(), rb(), ev(0,0,0,0,1,0,3'b001,0,0,fault_m));
        push(junk, rb(), rb(), rb(), ev(0,1,0,0,1,1,3'b001,0,0,fault_m));
      end
      6'd3: begin
        push(junk, rb(), rb(), rb(), ev(0,0,0,0,1,0,3'b000,0,0,fault_m));
        push(junk, rb(), rb(), rb(), ev(0,1,0,0,1,1,3'b000,0,0,fault_m));
      end
      6'd4: begin
        push(junk, rb(), rb(), rb(), ev(0,0,0,0,0,0,3'b000,1,0,fault_m));
        for (int k = 1; k <= MUL_TIMEOUT; k++) begin
          if (k == lat) begin
            push(junk, rb(), 1'b1, rb(), ev(0,0,0,0,0,0,3'b000,0,1,fault_m));
            push(junk, rb(), rb(), rb(), ev(0,1,0,0,0,1,3'b000,0,0,fault_m));
            break;
          end else if (k == MUL_TIMEOUT) begin
            push(junk, rb(), 1'b0, rb(), ev(0,1,0,0,0,0,3'b000,0,1,fault_m));
            fault_m = 1'b1;
          end else begin
            push(junk, rb(), 1'b0, rb(), ev(0,0,0,0,0,0,3'b000,0,1,fault_m));
          end
        end
      end
      6'd5: push(junk, zb, rb(), rb(), ev(0,!zb,zb,0,0,0,3'b010,0,0,fault_m));
      6'd6: push(junk, rb(), rb(), rb(), ev(0,0,0,1,0,0,3'b000,0,0,fault_m));
      6'd7: begin
        push(junk, rb(), rb(), rb(), ev(0,0,0,0,0,0,3'b000,0,0,fault_m));
        for (int k = 0; k < pre; k++)
          push(junk, rb(), rb(), 1'b0, ev(0,0,0,0,0,0,3'b000,0,1,fault_m));
        for (int k = 0; k < hi; k++)
          push(junk, rb(), rb(), 1'b1, ev(0,0,0,0,0,0,3'b000,0,1,fault_m));
        push(junk, rb(), rb(), 1'b0, ev(0,1,0,0,0,0,3'b000,0,1,fault_m));
      end
      default: push(junk, rb(), rb(), rb(), ev(0,1,0,0,0,0,3'b000,0,0,fault_m));
    endcase
  endtask

  // Move the first keep cycles of the expanded instruction into the script
  task automatic commit(input int keep, input string tag);
    int n;
    n = (keep < tmp_q.size()) ? keep : tmp_q.size();
    for (int i = 0; i < n; i++) stim_q.push_back(tmp_q[i]);
    $display("txn %0d: %s op=%b cycles=%0d of %0d", stim_q.size(), tag,
             tmp_q[0].op, n, tmp_q.size());
  endtask

  task automatic add_reset(input int n, input logic [5:0] op);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c.rst = 1'b1; c.op = op; c.zz = rb(); c.md = rb(); c.sw = rb(); c.exp = '0;
      stim_q.push_back(c);
    end
    fault_m = 1'b0;
    $display("txn %0d: reset for %0d cycles", stim_q.size(), n);
  endtask

  task automatic pin(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: model gives %0h, hand value %0h", name, got, want);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the script
  always @(negedge clk) begin
    logic [11:0] got;
    #3;
    if (chk_en) begin
      got = {ir_load, PCincr, PCrelbranch, PCabsbranch, imm, w1, ALUfunc,
             mul_start, busy, fault};
      n_vec++;
      if (got !== exp_cur) begin
        n_bad++;
        $display("FAIL outputs cycle %0d: got %b expected %b", cyc_idx, got, exp_cur);
      end
      n_vec++;
      if ($countones({PCincr, PCrelbranch, PCabsbranch}) > 1) begin
        n_bad++;
        $display("FAIL pc_strobe cycle %0d: got %b expected at most one set",
                 cyc_idx, {PCincr, PCrelbranch, PCabsbranch});
      end
    end
  end

  initial begin
    logic [5:0] op;
    int lat, pre, hi, keep;

    // Directed sequences from the test plan
    add_reset(3, 6'b000001);
    expand(6'b000010, 0, 0, 0, 0);
    pin("addi_len", tmp_q.size(), 4);
    pin("addi_wb", int'(tmp_q[3].exp), int'(12'b010011001000));
    commit(99, "ADDI");
    expand(6'b000101, 1, 0, 0, 0);
    pin("beq_len", tmp_q.size(), 3);
    pin("beq_taken", int'(tmp_q[2].exp), int'(12'b001000010000));
    commit(99, "BEQ z=1");
    expand(6'b000101, 0, 0, 0, 0);
    commit(99, "BEQ z=0");
    expand(6'b000100, 0, 5, 0, 0);
    pin("mul5_len", tmp_q.size(), 9);
    commit(99, "MUL done@5");
    expand(6'b000100, 0, 999, 0, 0);
    pin("mul_to_len", tmp_q.size(), 3 + MUL_TIMEOUT);
    pin("mul_to_last", int'(tmp_q[2 + MUL_TIMEOUT].exp), int'(12'b010000000010));
    commit(99, "MUL timeout");
    add_reset(1, 6'b000000);
    expand(6'b000111, 0, 0, 4, 3);
    commit(99, "WAITSW low4 high3");
    expand(6'b000111, 0, 0, 0, 2);
    commit(99, "WAITSW high on entry");
    expand(6'b111111, 0, 0, 0, 0);
    pin("illegal_exec_fault", int'(tmp_q[2].exp), int'(12'b010000000001));
    commit(99, "illegal");
    expand(6'b000100, 0, 999, 0, 0);
    commit(8, "MUL aborted");
    add_reset(2, 6'b000100);
    expand(6'b000001, 0, 0, 0, 0);
    commit(99, "ADD after reset");

    // Randomized instruction stream with occasional mid-instruction reset
    for (int t = 0; t < 150; t++) begin
      op  = ($urandom_range(0, 9) < 8) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      lat = $urandom_range(1, MUL_TIMEOUT + 3);
      pre = $urandom_range(0, 4);
      hi  = $urandom_range(1, 3);
      expand(op, rb(), lat, pre, hi);
      if ($urandom_range(0, 11) == 0) begin
        keep = $urandom_range(1, tmp_q.size());
        commit(keep, "random+abort");
        add_reset($urandom_range(1, 2), 6'($urandom));
      end else begin
        commit(99, "random");
      end
    end

    // Replay
    for (int i = 0; i < stim_q.size(); i++) begin
      @(negedge clk);
      reset        = stim_q[i].rst;
      instr_opcode = stim_q[i].op;
      z            = stim_q[i].zz;
      mul_done     = stim_q[i].md;
      sw_go        = stim_q[i].sw;
      exp_cur      = stim_q[i].exp;
      cyc_idx      = i;
      chk_en       = 1'b1;
    end
    @(negedge clk);
    chk_en = 1'b0;
    #10;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
